// File: rtl/sb_tx_pkg.sv
// sb_tx_pkg -- shared definitions for the sideband transmit arbiter.
// Holds the FSM state encoding, the reserved transaction codes and the
// default parameter values used by sb_tx_arbiter.
package sb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SENT = 3'd1,
        ST_RETRY     = 3'd2,
        ST_GAP       = 3'd3,
        ST_DISC      = 3'd4
    } sb_tx_state_e;

    localparam logic [2:0] TRANS_NONE = 3'b000;
    localparam logic [2:0] TRANS_DISC = 3'b111;

    localparam int DEF_TIMEOUT_CYCLES = 1000;
    localparam int DEF_MAX_RETRY      = 2;
    localparam int DEF_GAP_CYCLES     = 4;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester round-robin arbiter.
// Ports:
//   clk, rst   clock and asynchronous active-low reset
//   req[1:0]   request levels
//   advance    high when the current grant is being consumed
//   grant[1:0] one-hot grant (combinational from req and the pointer)
// The pointer favours req[0] after reset and afterwards favours the
// requester that was not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic       ptr_r;
    logic [1:0] grant_s;

    // Pick the favoured requester if it asks, otherwise the other one.
    always_comb begin
        grant_s = 2'b00;
        case (ptr_r)
            1'b0: begin
                if (req[0]) begin
                    grant_s = 2'b01;
                end else if (req[1]) begin
                    grant_s = 2'b10;
                end else begin
                    grant_s = 2'b00;
                end
            end
            1'b1: begin
                if (req[1]) begin
                    grant_s = 2'b10;
                end else if (req[0]) begin
                    grant_s = 2'b01;
                end else begin
                    grant_s = 2'b00;
                end
            end
            default: grant_s = 2'b00;
        endcase
    end

    // Move the pointer away from whoever was just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= 1'b0;
        end else if (advance && (grant_s != 2'b00)) begin
            ptr_r <= grant_s[0];
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant = grant_s;

endmodule

// File: rtl/sb_tx_arbiter.sv
// sb_tx_arbiter -- arbitrates FSM and register-response requests onto the
// sideband transaction generator, with timeout/retry and a forced
// disconnect code.
// Ports:
//   sb_clk, rst          sideband clock, asynchronous active-low reset
//   req_fsm/req_fsm_sel  control FSM request level and its code
//   req_rsp/req_rsp_sel  register-response request level and its code
//   disconnect_req       level forcing the disconnect code
//   trans_sent           completion pulse from the transaction generator
//   trans_sel            code to the generator (000 = none)
//   gnt_fsm, gnt_rsp     one-cycle accept pulses
//   busy                 high whenever the FSM is not IDLE
//   timeout_err          one-cycle pulse when a request is abandoned
module sb_tx_arbiter
    import sb_tx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRY      = DEF_MAX_RETRY,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       req_fsm,
    input  logic [2:0] req_fsm_sel,
    input  logic       req_rsp,
    input  logic [2:0] req_rsp_sel,
    input  logic       disconnect_req,
    input  logic       trans_sent,
    output logic [2:0] trans_sel,
    output logic       gnt_fsm,
    output logic       gnt_rsp,
    output logic       busy,
    output logic       timeout_err
);

    // A width of at least 1 keeps degenerate parameter values legal.
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sb_tx_state_e     state_r;
    logic [2:0]       code_r;
    logic [2:0]       trans_sel_r;
    logic             gnt_fsm_r;
    logic             gnt_rsp_r;
    logic             busy_r;
    logic             timeout_err_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic [1:0]       retry_cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;

    logic [1:0]       grant_s;
    logic             advance_s;
    logic [2:0]       pick_code_s;

    // Bit 0 is the response requester so it is favoured after reset.
    rr_arb2 u_rr_arb2 (
        .clk     (sb_clk),
        .rst     (rst),
        .req     ({req_fsm, req_rsp}),
        .advance (advance_s),
        .grant   (grant_s)
    );

    // Arbitration only consumes a grant in IDLE without a disconnect.
    always_comb begin
        advance_s = 1'b0;
        if ((state_r == ST_IDLE) && !disconnect_req) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    // Code belonging to the requester the arbiter selected.
    always_comb begin
        pick_code_s = TRANS_NONE;
        if (grant_s[0]) begin
            pick_code_s = req_rsp_sel;
        end else begin
            pick_code_s = req_fsm_sel;
        end
    end

    // Main control FSM; every output is a register updated here.
    always_ff @(posedge sb_clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            code_r        <= TRANS_NONE;
            trans_sel_r   <= TRANS_NONE;
            gnt_fsm_r     <= 1'b0;
            gnt_rsp_r     <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            to_cnt_r      <= {TO_W{1'b0}};
            retry_cnt_r   <= 2'b00;
            gap_cnt_r     <= {GAP_W{1'b0}};
        end else begin
            gnt_fsm_r     <= 1'b0;
            gnt_rsp_r     <= 1'b0;
            timeout_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (disconnect_req) begin
                        state_r     <= ST_DISC;
                        trans_sel_r <= TRANS_DISC;
                        busy_r      <= 1'b1;
                    end else if (grant_s != 2'b00) begin
                        gnt_rsp_r   <= grant_s[0];
                        gnt_fsm_r   <= grant_s[1];
                        busy_r      <= 1'b1;
                        to_cnt_r    <= {TO_W{1'b0}};
                        retry_cnt_r <= 2'b00;
                        code_r      <= pick_code_s;
                        trans_sel_r <= pick_code_s;
                        // A null code is accepted but never issued.
                        if (pick_code_s == TRANS_NONE) begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= {GAP_W{1'b0}};
                        end else begin
                            state_r <= ST_WAIT_SENT;
                        end
                    end else begin
                        trans_sel_r <= TRANS_NONE;
                        busy_r      <= 1'b0;
                    end
                end
                ST_WAIT_SENT: begin
                    // Completion has priority over the terminal count, and
                    // a pending disconnect only takes over once we finish.
                    if (trans_sent || ((to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) &&
                                       !(retry_cnt_r < 2'(MAX_RETRY)))) begin
                        timeout_err_r <= !trans_sent;
                        if (disconnect_req) begin
                            state_r     <= ST_DISC;
                            trans_sel_r <= TRANS_DISC;
                        end else begin
                            state_r     <= ST_GAP;
                            trans_sel_r <= TRANS_NONE;
                            gap_cnt_r   <= {GAP_W{1'b0}};
                        end
                    end else if (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_r     <= ST_RETRY;
                        trans_sel_r <= TRANS_NONE;
                        if (retry_cnt_r != 2'b11) begin
                            retry_cnt_r <= retry_cnt_r + 2'b01;
                        end else begin
                            retry_cnt_r <= retry_cnt_r;
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RETRY: begin
                    to_cnt_r <= {TO_W{1'b0}};
                    if (disconnect_req) begin
                        state_r     <= ST_DISC;
                        trans_sel_r <= TRANS_DISC;
                    end else begin
                        state_r     <= ST_WAIT_SENT;
                        trans_sel_r <= code_r;
                    end
                end
                ST_GAP: begin
                    if (disconnect_req) begin
                        state_r     <= ST_DISC;
                        trans_sel_r <= TRANS_DISC;
                    end else if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + {{(GAP_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DISC: begin
                    if (!disconnect_req) begin
                        state_r     <= ST_GAP;
                        trans_sel_r <= TRANS_NONE;
                        gap_cnt_r   <= {GAP_W{1'b0}};
                    end else begin
                        trans_sel_r <= TRANS_DISC;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    trans_sel_r <= TRANS_NONE;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign trans_sel   = trans_sel_r;
    assign gnt_fsm     = gnt_fsm_r;
    assign gnt_rsp     = gnt_rsp_r;
    assign busy        = busy_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed testbench for sb_tx_arbiter (TIMEOUT_CYCLES=8, MAX_RETRY=2,
// GAP_CYCLES=4). Inputs change #1 after a rising edge; outputs are
// checked at the same point, so they reflect the edge just taken.
module tb_sb_tx_arbiter;

    logic       sb_clk;
    logic       rst;
    logic       req_fsm;
    logic [2:0] req_fsm_sel;
    logic       req_rsp;
    logic [2:0] req_rsp_sel;
    logic       disconnect_req;
    logic       trans_sent;
    logic [2:0] trans_sel;
    logic       gnt_fsm;
    logic       gnt_rsp;
    logic       busy;
    logic       timeout_err;

    int n_checks;
    int n_errors;

    sb_tx_arbiter #(
        .TIMEOUT_CYCLES (8),
        .MAX_RETRY      (2),
        .GAP_CYCLES     (4)
    ) dut (
        .sb_clk         (sb_clk),
        .rst            (rst),
        .req_fsm        (req_fsm),
        .req_fsm_sel    (req_fsm_sel),
        .req_rsp        (req_rsp),
        .req_rsp_sel    (req_rsp_sel),
        .disconnect_req (disconnect_req),
        .trans_sent     (trans_sent),
        .trans_sel      (trans_sel),
        .gnt_fsm        (gnt_fsm),
        .gnt_rsp        (gnt_rsp),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    // 10 time-unit clock.
    initial begin
        sb_clk = 1'b0;
        forever #5 sb_clk = ~sb_clk;
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Complete the current transaction and let the gap run out.
    task automatic finish_txn(input string tag);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        chk({tag, "_sel_cleared"}, 32'(trans_sel), 32'd0);
        repeat (4) tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        req_fsm        = 1'b0;
        req_fsm_sel    = 3'b000;
        req_rsp        = 1'b0;
        req_rsp_sel    = 3'b000;
        disconnect_req = 1'b0;
        trans_sent     = 1'b0;

        // Reset state.
        #2 rst = 1'b0;
        #1;
        chk("rst_sel", 32'(trans_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_gnt", 32'({gnt_fsm, gnt_rsp}), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        @(negedge sb_clk);
        rst = 1'b1;
        tick();
        chk("idle_sel", 32'(trans_sel), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single request.
        req_fsm = 1'b1; req_fsm_sel = 3'b010;
        tick();
        chk("single_gnt_fsm", 32'(gnt_fsm), 32'd1);
        chk("single_gnt_rsp", 32'(gnt_rsp), 32'd0);
        chk("single_sel", 32'(trans_sel), 32'd2);
        chk("single_busy", 32'(busy), 32'd1);
        req_fsm = 1'b0;
        tick();
        chk("single_gnt_pulse", 32'(gnt_fsm), 32'd0);
        chk("single_sel_hold", 32'(trans_sel), 32'd2);
        tick();
        chk("single_sel_hold2", 32'(trans_sel), 32'd2);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        chk("single_sel_done", 32'(trans_sel), 32'd0);
        chk("single_gap_busy", 32'(busy), 32'd1);
        req_rsp = 1'b1; req_rsp_sel = 3'b011;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("gap_no_gnt", 32'(gnt_rsp), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("gap_end_busy", 32'(busy), 32'd0);
        chk("gap_end_no_gnt", 32'(gnt_rsp), 32'd0);
        req_rsp = 1'b0;

        // Contention straight after a reset: rsp first, then fsm, then rsp.
        rst = 1'b0;
        @(negedge sb_clk);
        rst = 1'b1;
        req_fsm = 1'b1; req_fsm_sel = 3'b010;
        req_rsp = 1'b1; req_rsp_sel = 3'b011;
        tick();
        chk("cont1_gnt_rsp", 32'(gnt_rsp), 32'd1);
        chk("cont1_gnt_fsm", 32'(gnt_fsm), 32'd0);
        chk("cont1_sel", 32'(trans_sel), 32'd3);
        req_rsp = 1'b0;
        tick();
        chk("cont1_fsm_pending", 32'(gnt_fsm), 32'd0);
        finish_txn("cont1");
        chk("cont1_no_gnt_in_gap", 32'(gnt_fsm), 32'd0);
        tick();
        chk("cont2_gnt_fsm", 32'(gnt_fsm), 32'd1);
        chk("cont2_sel", 32'(trans_sel), 32'd2);
        req_fsm = 1'b0;
        tick();
        finish_txn("cont2");
        req_fsm = 1'b1; req_rsp = 1'b1;
        tick();
        chk("cont3_gnt_rsp", 32'(gnt_rsp), 32'd1);
        chk("cont3_gnt_fsm", 32'(gnt_fsm), 32'd0);
        req_fsm = 1'b0; req_rsp = 1'b0;
        tick();
        finish_txn("cont3");

        // Retries exhausted: issues at +0, +9, +18, abandon at +26.
        req_fsm = 1'b1; req_fsm_sel = 3'b010;
        tick();
        chk("retry_gnt", 32'(gnt_fsm), 32'd1);
        req_fsm = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            tick();
            chk($sformatf("retry_sel_%0d", k), 32'(trans_sel),
                ((k == 8) || (k == 17) || (k >= 26)) ? 32'd0 : 32'd2);
            chk($sformatf("retry_err_%0d", k), 32'(timeout_err),
                (k == 26) ? 32'd1 : 32'd0);
        end
        repeat (3) tick();
        chk("retry_idle", 32'(busy), 32'd0);

        // Disconnect raised mid-transaction.
        req_fsm = 1'b1; req_fsm_sel = 3'b010;
        tick();
        req_fsm = 1'b0;
        disconnect_req = 1'b1;
        tick();
        chk("disc_hold1", 32'(trans_sel), 32'd2);
        req_rsp = 1'b1; req_rsp_sel = 3'b011;
        tick();
        chk("disc_hold2", 32'(trans_sel), 32'd2);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        chk("disc_code", 32'(trans_sel), 32'd7);
        chk("disc_no_gnt", 32'({gnt_fsm, gnt_rsp}), 32'd0);
        repeat (2) tick();
        chk("disc_code_hold", 32'(trans_sel), 32'd7);
        chk("disc_no_gnt2", 32'({gnt_fsm, gnt_rsp}), 32'd0);
        req_rsp = 1'b0;
        disconnect_req = 1'b0;
        tick();
        chk("disc_release_sel", 32'(trans_sel), 32'd0);
        chk("disc_release_busy", 32'(busy), 32'd1);
        repeat (4) tick();
        chk("disc_idle", 32'(busy), 32'd0);
        disconnect_req = 1'b1;
        tick();
        chk("disc_from_idle", 32'(trans_sel), 32'd7);
        disconnect_req = 1'b0;
        tick();
        chk("disc_from_idle_clr", 32'(trans_sel), 32'd0);
        repeat (4) tick();

        // trans_sent at the terminal count wins over the retry.
        req_fsm = 1'b1; req_fsm_sel = 3'b100;
        tick();
        req_fsm = 1'b0;
        repeat (7) tick();
        chk("tc_sel_before", 32'(trans_sel), 32'd4);
        trans_sent = 1'b1;
        tick();
        trans_sent = 1'b0;
        chk("tc_sel", 32'(trans_sel), 32'd0);
        chk("tc_no_err", 32'(timeout_err), 32'd0);
        tick();
        chk("tc_no_retry", 32'(trans_sel), 32'd0);
        repeat (3) tick();
        chk("tc_idle", 32'(busy), 32'd0);

        // Null code: granted, never issued, straight to the gap.
        req_rsp = 1'b1; req_rsp_sel = 3'b000;
        tick();
        chk("null_gnt", 32'(gnt_rsp), 32'd1);
        chk("null_sel", 32'(trans_sel), 32'd0);
        chk("null_busy", 32'(busy), 32'd1);
        req_rsp = 1'b0;
        repeat (3) tick();
        chk("null_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("null_idle", 32'(busy), 32'd0);

        // Reset in the middle of a transaction.
        req_fsm = 1'b1; req_fsm_sel = 3'b010;
        tick();
        chk("mid_gnt", 32'(gnt_fsm), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(trans_sel), 32'd0);
        chk("mid_rst_gnt", 32'(gnt_fsm), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_err", 32'(timeout_err), 32'd0);
        @(negedge sb_clk);
        rst = 1'b1;
        req_fsm_sel = 3'b101;
        tick();
        chk("rereq_gnt", 32'(gnt_fsm), 32'd1);
        chk("rereq_sel", 32'(trans_sel), 32'd5);
        req_fsm = 1'b0;
        tick();
        finish_txn("rereq");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
